// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } scan_state_t;

  // Row patterns are handled zero-extended to this width (NROWS <= 32).
  localparam int unsigned MAX_ROWS = 32;

  function automatic int unsigned lowest_set_bit(input logic [MAX_ROWS-1:0] v);
    logic found;
    lowest_set_bit = 0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (v[i] && !found) begin
        lowest_set_bit = unsigned'(i);
        found = 1'b1;
      end
    end
  endfunction

  function automatic int unsigned popcount(input logic [MAX_ROWS-1:0] v);
    popcount = 0;
    for (int i = 0; i < 32; i++) begin
      popcount = popcount + 32'(v[i]);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row debounce, press/repeat/release events.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned NROWS        = 4,
  parameter int unsigned NCOLS        = 4,
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE     = 8,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             repeat_en,
  input  logic [NROWS-1:0]                 read_row,
  output logic [NCOLS-1:0]                 scan_col,
  output logic                             key_valid,
  output logic                             key_repeat,
  output logic                             key_release,
  output logic [$clog2(NROWS*NCOLS)-1:0]   key_code,
  output logic                             key_multi,
  output logic                             key_held
);

  localparam int unsigned CODE_W = $clog2(NROWS * NCOLS);
  localparam int unsigned COL_W  = $clog2(NCOLS);
  localparam int unsigned MAX_A  = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int unsigned MAX_B  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned MAXP   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W  = $clog2(MAXP) + 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT   = CNT_W'(REPEAT_RATE - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NCOLS - 1);

  logic [NROWS-1:0] srow;

  keypad_sync #(.WIDTH(NROWS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (read_row),
    .q   (srow)
  );

  scan_state_t       state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, col_next;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0]  deb_q, deb_d;
  logic [CNT_W-1:0]  rpt_q, rpt_d;
  logic              rpt_started_q, rpt_started_d;
  logic [NROWS-1:0]  pat_q, pat_d;

  logic [NCOLS-1:0]  scan_col_d;
  logic              key_valid_d, key_repeat_d, key_release_d, key_multi_d, key_held_d;
  logic [CODE_W-1:0] key_code_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign col_next = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    dwell_d       = dwell_q;
    deb_d         = deb_q;
    rpt_d         = rpt_q;
    rpt_started_d = rpt_started_q;
    pat_d         = pat_q;
    key_valid_d   = 1'b0;
    key_repeat_d  = 1'b0;
    key_release_d = 1'b0;
    key_code_d    = key_code;
    key_multi_d   = key_multi;

    if (!enable) begin
      state_d       = ST_IDLE;
      col_d         = '0;
      dwell_d       = '0;
      deb_d         = '0;
      rpt_d         = '0;
      rpt_started_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SCAN;
          col_d   = '0;
          dwell_d = '0;
        end
        ST_SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (|srow) begin
              pat_d   = srow;
              deb_d   = '0;
              state_d = ST_DEBOUNCE;
            end else begin
              col_d = col_next;
            end
          end else begin
            dwell_d = sat_inc(dwell_q);
          end
        end
        ST_DEBOUNCE: begin
          if (srow == pat_q) begin
            if (deb_q == DEB_LAST) begin
              key_valid_d   = 1'b1;
              key_code_d    = CODE_W'(lowest_set_bit(32'(pat_q)) * NCOLS + 32'(col_q));
              key_multi_d   = (popcount(32'(pat_q)) > 32'd1);
              rpt_d         = '0;
              rpt_started_d = 1'b0;
              state_d       = ST_HELD;
            end else begin
              deb_d = sat_inc(deb_q);
            end
          end else begin
            col_d   = col_next;
            dwell_d = '0;
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (srow == '0) begin
            deb_d   = '0;
            state_d = ST_RELEASE;
          end else if (!repeat_en) begin
            // Holding the timer at zero makes a later rising repeat_en restart it.
            rpt_d         = '0;
            rpt_started_d = 1'b0;
          end else if ((!rpt_started_q && rpt_q == RPT_FIRST) ||
                       (rpt_started_q && rpt_q == RPT_NEXT)) begin
            key_valid_d   = 1'b1;
            key_repeat_d  = 1'b1;
            rpt_d         = '0;
            rpt_started_d = 1'b1;
          end else begin
            rpt_d = sat_inc(rpt_q);
          end
        end
        ST_RELEASE: begin
          if (srow == '0) begin
            if (deb_q == DEB_LAST) begin
              key_release_d = 1'b1;
              col_d         = col_next;
              dwell_d       = '0;
              state_d       = ST_SCAN;
            end else begin
              deb_d = sat_inc(deb_q);
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    scan_col_d = (state_d == ST_IDLE) ? '1 : ~(NCOLS'(1) << col_d);
    key_held_d = (state_d == ST_HELD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      dwell_q       <= '0;
      deb_q         <= '0;
      rpt_q         <= '0;
      rpt_started_q <= 1'b0;
      pat_q         <= '0;
      scan_col      <= '1;
      key_valid     <= 1'b0;
      key_repeat    <= 1'b0;
      key_release   <= 1'b0;
      key_code      <= '0;
      key_multi     <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      dwell_q       <= dwell_d;
      deb_q         <= deb_d;
      rpt_q         <= rpt_d;
      rpt_started_q <= rpt_started_d;
      pat_q         <= pat_d;
      scan_col      <= scan_col_d;
      key_valid     <= key_valid_d;
      key_repeat    <= key_repeat_d;
      key_release   <= key_release_d;
      key_code      <= key_code_d;
      key_multi     <= key_multi_d;
      key_held      <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a 4x4 key-matrix model.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       repeat_en;
  logic [3:0] read_row;
  logic [3:0] scan_col;
  logic       key_valid;
  logic       key_repeat;
  logic       key_release;
  logic [3:0] key_code;
  logic       key_multi;
  logic       key_held;

  keypad_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .repeat_en   (repeat_en),
    .read_row    (read_row),
    .scan_col    (scan_col),
    .key_valid   (key_valid),
    .key_repeat  (key_repeat),
    .key_release (key_release),
    .key_code    (key_code),
    .key_multi   (key_multi),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  // kind: 0 press, 1 repeat, 2 release; lo/hi: allowed cycle window
  typedef struct {
    int kind;
    int code;
    int multi;
    int lo;
    int hi;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         mon_kind;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [15:0] keys = '0;   // keys[r*4+c] = switch at row r, column c closed

  always @(posedge clk) cyc <= cyc + 1;

  // A closed switch pulls its row high only while its column is driven low.
  always_comb begin
    read_row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !scan_col[c]) read_row[r] = 1'b1;
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (key_valid || key_release) begin
      mon_kind = key_release ? 2 : (key_repeat ? 1 : 0);
      n_cmp++;
      if (key_valid && key_release) begin
        n_bad++;
        $display("FAIL overlap cyc=%0d: key_valid and key_release both 1, required exclusive", cyc);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d: kind=%0d code=%0d, required no event", cyc, mon_kind, key_code);
      end else begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        if (mon_kind !== mon_e.kind) begin
          n_bad++;
          $display("FAIL event_kind cyc=%0d: got %0d, required %0d", cyc, mon_kind, mon_e.kind);
        end
        n_cmp++;
        if (int'(key_code) !== mon_e.code) begin
          n_bad++;
          $display("FAIL key_code cyc=%0d: got %0d, required %0d", cyc, key_code, mon_e.code);
        end
        n_cmp++;
        if (int'(key_multi) !== mon_e.multi) begin
          n_bad++;
          $display("FAIL key_multi cyc=%0d: got %0d, required %0d", cyc, key_multi, mon_e.multi);
        end
        n_cmp++;
        if (cyc < mon_e.lo || cyc > mon_e.hi) begin
          n_bad++;
          $display("FAIL event_time kind=%0d: got cycle %0d, required %0d..%0d", mon_e.kind, cyc, mon_e.lo, mon_e.hi);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push(input int kind, input int code, input int multi, input int lo, input int hi);
    exp_t e;
    e.kind = kind; e.code = code; e.multi = multi; e.lo = lo; e.hi = hi;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget, output bit to);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    to = (exp_q.size() != 0);
    if (to) exp_q.delete();
  endtask

  // Waits for the cycle in which column pattern pat is newly driven.
  task automatic wait_entry(input logic [3:0] pat, input int budget, output bit to);
    int n = 0;
    while (scan_col == pat && n < budget) begin @(negedge clk); n++; end
    while (scan_col != pat && n < budget) begin @(negedge clk); n++; end
    to = (scan_col != pat);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; repeat_en = 1'b0; keys = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({scan_col, key_valid, key_repeat, key_release, key_held, key_multi, key_code} !== {4'b1111, 5'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got col=%b v=%b r=%b rel=%b h=%b m=%b code=%0d, required col=1111 all 0",
               scan_col, key_valid, key_repeat, key_release, key_held, key_multi, key_code);
    end
  endtask

  task automatic test_scan_idle;
    logic [3:0] exp_col;
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k - 1) / 4) % 4);
      n_cmp++;
      if (scan_col !== exp_col) begin
        n_bad++;
        $display("FAIL scan_seq k=%0d: got %b, required %b", k, scan_col, exp_col);
      end
    end
  endtask

  task automatic test_single_key;
    bit to;
    int t;
    wait_entry(4'b1101, 60, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL single_wait_col: column 1 never driven, required 1101"); end
    t = cyc;
    keys[2*4+1] = 1'b1;
    push(0, 9, 0, t + 11, t + 13);
    drain(40, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL single_press: no press event, required code 9"); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({scan_col, key_held} !== {4'b1101, 1'b1}) begin
      n_bad++;
      $display("FAIL single_frozen: got col=%b held=%b, required col=1101 held=1", scan_col, key_held);
    end
    t = cyc;
    keys = '0;
    push(2, 9, 0, t + 11, t + 11);
    drain(30, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL single_release: no release event, required one"); end
    n_cmp++;
    if ({scan_col, key_held} !== {4'b1011, 1'b0}) begin
      n_bad++;
      $display("FAIL single_resume: got col=%b held=%b, required col=1011 held=0", scan_col, key_held);
    end
  endtask

  task automatic test_bounce;
    bit to;
    int t;
    for (int i = 0; i < 10; i++) begin
      keys[1*4+3] = ~keys[1*4+3];
      repeat (3) @(negedge clk);
    end
    t = cyc;
    keys[1*4+3] = 1'b1;
    push(0, 7, 0, t + 10, t + 40);
    drain(60, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bounce_press: no press after stable period, required code 7"); end
    repeat (3) @(negedge clk);
    t = cyc;
    keys = '0;
    push(2, 7, 0, t + 11, t + 11);
    drain(30, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bounce_release: no release event, required one"); end
  endtask

  task automatic test_repeat;
    bit to;
    int t;
    int p;
    int n = 0;
    repeat_en = 1'b1;
    t = cyc;
    keys[0*4+2] = 1'b1;
    push(0, 2, 0, t + 10, t + 40);
    while (!key_valid && n < 80) begin @(negedge clk); n++; end
    n_cmp++;
    if (!key_valid) begin n_bad++; $display("FAIL repeat_press: got no key_valid, required press"); end
    p = cyc;
    for (int k = 0; k < 5; k++) push(1, 2, 0, p + 20 + 10*k, p + 20 + 10*k);
    while (cyc < p + 65) @(negedge clk);
    t = cyc;
    keys = '0;
    push(2, 2, 0, t + 11, t + 11);
    drain(40, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL repeat_events: missing repeat/release events, required 5 repeats and release"); end
    repeat_en = 1'b0;
  endtask

  task automatic test_multi;
    bit to;
    int t;
    t = cyc;
    keys[0*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    push(0, 0, 1, t + 10, t + 40);
    drain(60, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL multi_press: no press event, required code 0 multi 1"); end
    t = cyc;
    keys = '0;
    push(2, 0, 1, t + 11, t + 11);
    drain(30, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL multi_release: no release event, required one"); end
  endtask

  task automatic test_enable_drop;
    bit to;
    int t;
    t = cyc;
    keys[3*4+2] = 1'b1;
    push(0, 14, 0, t + 10, t + 40);
    drain(60, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL endrop_press: no press event, required code 14"); end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({scan_col, key_held, key_valid, key_release} !== {4'b1111, 3'b000}) begin
      n_bad++;
      $display("FAIL endrop_idle: got col=%b held=%b v=%b rel=%b, required col=1111 others 0",
               scan_col, key_held, key_valid, key_release);
    end
    keys = '0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (key_code !== 4'd14) begin
      n_bad++;
      $display("FAIL endrop_code: got %0d, required 14", key_code);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_debounce;
    bit to;
    wait_entry(4'b1110, 60, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL rstmid_wait_col: column 0 never driven, required 1110"); end
    keys[1*4+0] = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1; enable = 1'b0; keys = '0;
    @(negedge clk);
    n_cmp++;
    if ({scan_col, key_valid, key_repeat, key_release, key_held, key_multi, key_code} !== {4'b1111, 5'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL rstmid_state: got col=%b v=%b r=%b rel=%b h=%b m=%b code=%0d, required col=1111 all 0",
               scan_col, key_valid, key_repeat, key_release, key_held, key_multi, key_code);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scan_idle();
    test_single_key();
    test_bounce();
    test_repeat();
    test_multi();
    test_enable_drop();
    test_reset_mid_debounce();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
